// File: rtl/branch_resolve_unit_pkg.sv
// Shared constants for the branch resolve slice: branch/jump opcode
// encodings, default bus widths and the "free" (idle) bus values.
package branch_resolve_unit_pkg;

  localparam int INST_ADDR_BUS_W = 32;
  localparam int DATA_BUS_W      = 32;
  localparam int OP_BUS_W        = 6;

  localparam logic [OP_BUS_W-1:0] OP_NOP  = 6'h00;
  localparam logic [OP_BUS_W-1:0] OP_BEQ  = 6'h01;
  localparam logic [OP_BUS_W-1:0] OP_BNE  = 6'h02;
  localparam logic [OP_BUS_W-1:0] OP_BLT  = 6'h03;
  localparam logic [OP_BUS_W-1:0] OP_BGE  = 6'h04;
  localparam logic [OP_BUS_W-1:0] OP_BLTU = 6'h05;
  localparam logic [OP_BUS_W-1:0] OP_BGEU = 6'h06;
  localparam logic [OP_BUS_W-1:0] OP_JAL  = 6'h07;
  localparam logic [OP_BUS_W-1:0] OP_JALR = 6'h08;

  localparam logic [INST_ADDR_BUS_W-1:0] ADDR_FREE = '0;
  localparam logic [DATA_BUS_W-1:0]      DATA_FREE = '0;

  function automatic logic is_link_op(input logic [OP_BUS_W-1:0] op);
    return (op == OP_JAL) || (op == OP_JALR);
  endfunction

endpackage

// File: rtl/branch_resolve_unit_redirect_fifo.sv
// Redirect FIFO: synchronous FIFO with a registered head.
// Ports:
//   clk, rst (sync, active-high), i_rdy (global enable; all state holds when low)
//   i_push / i_din      : write request and data
//   i_pop_ready         : consumer accepts head this cycle
//   o_head_valid/o_head_data : registered head entry
//   o_full              : occupancy == DEPTH (combinational)
//   o_drop              : push rejected this cycle (full, no simultaneous pop)
module redirect_fifo
  import branch_resolve_unit_pkg::*;
#(
  parameter int W     = 33,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_rdy,
  input  logic         i_push,
  input  logic [W-1:0] i_din,
  input  logic         i_pop_ready,
  output logic         o_head_valid,
  output logic [W-1:0] o_head_data,
  output logic         o_full,
  output logic         o_drop
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]     r_mem [DEPTH];
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W:0]   r_count;
  logic             r_head_valid;
  logic [W-1:0]     r_head_data;

  logic             w_full;
  logic             w_pop;
  logic             w_push_ok;
  logic [PTR_W-1:0] w_rd_next;
  logic [PTR_W:0]   w_count_next;
  logic [W-1:0]     w_head_next;

  assign w_full    = (r_count == (PTR_W+1)'(DEPTH));
  assign w_pop     = i_rdy & r_head_valid & i_pop_ready;
  // A pop in the same cycle frees a slot, so a full FIFO still accepts.
  assign w_push_ok = i_rdy & i_push & (~w_full | w_pop);
  assign o_drop    = i_rdy & i_push & w_full & ~w_pop;

  assign w_rd_next    = r_rd_ptr + PTR_W'(w_pop);
  assign w_count_next = r_count + (PTR_W+1)'(w_push_ok) - (PTR_W+1)'(w_pop);

  // The head register is loaded with whatever entry sits at the next read
  // pointer; that entry may be the one being written this very cycle.
  always_comb begin
    w_head_next = '0;
    if (w_count_next != '0) begin
      if (w_push_ok && (w_rd_next == r_wr_ptr)) begin
        w_head_next = i_din;
      end else begin
        w_head_next = r_mem[w_rd_next];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (i_rdy && w_push_ok) begin
      r_mem[r_wr_ptr] <= i_din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_ptr     <= '0;
      r_wr_ptr     <= '0;
      r_count      <= '0;
      r_head_valid <= 1'b0;
      r_head_data  <= '0;
    end else if (i_rdy) begin
      r_rd_ptr     <= w_rd_next;
      r_wr_ptr     <= r_wr_ptr + PTR_W'(w_push_ok);
      r_count      <= w_count_next;
      r_head_valid <= (w_count_next != '0);
      r_head_data  <= w_head_next;
    end
  end

  assign o_head_valid = r_head_valid;
  assign o_head_data  = r_head_data;
  assign o_full       = w_full;

endmodule

// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: evaluates one issued branch/jump per cycle, computes
// the next PC and link value, and queues {addr, taken} into the redirect
// FIFO drained by fetch. Keeps resolved/taken counters and a sticky overflow.
// Ports:
//   clk, rst (sync, active-high), rdy (global enable)
//   BranchWorkEn, operandO, operandT, imm, opCode, PC : issued branch
//   jumpValid, jumpAddr, jumpTaken, jumpReady          : redirect handshake
//   linkEn, linkData                                   : JAL/JALR link pulse
//   branchFull, overflow, statResolved, statTaken      : status
module branch_resolve_unit
  import branch_resolve_unit_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int OP_W   = 6,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              BranchWorkEn,
  input  logic [DATA_W-1:0] operandO,
  input  logic [DATA_W-1:0] operandT,
  input  logic [DATA_W-1:0] imm,
  input  logic [OP_W-1:0]   opCode,
  input  logic [ADDR_W-1:0] PC,
  output logic              jumpValid,
  output logic [ADDR_W-1:0] jumpAddr,
  output logic              jumpTaken,
  input  logic              jumpReady,
  output logic              linkEn,
  output logic [DATA_W-1:0] linkData,
  output logic              branchFull,
  output logic              overflow,
  output logic [31:0]       statResolved,
  output logic [31:0]       statTaken
);

  logic              w_accept;
  logic              w_taken;
  logic              w_is_link;
  logic              w_is_jalr;
  logic [ADDR_W-1:0] w_pc_plus4;
  logic [ADDR_W-1:0] w_pc_imm;
  logic [DATA_W-1:0] w_rs_sum;
  logic [ADDR_W-1:0] w_rs_sum_a;
  logic [ADDR_W-1:0] w_jalr_tgt;
  logic [ADDR_W-1:0] w_target;
  logic [ADDR_W:0]   w_head;
  logic              w_drop;

  logic              r_link_en;
  logic [DATA_W-1:0] r_link_data;
  logic              r_overflow;
  logic [31:0]       r_stat_resolved;
  logic [31:0]       r_stat_taken;

  assign w_accept = rdy & BranchWorkEn;

  always_comb begin
    w_taken   = 1'b0;
    w_is_link = 1'b0;
    w_is_jalr = 1'b0;
    case (opCode)
      OP_BEQ:  w_taken = (operandO == operandT);
      OP_BNE:  w_taken = (operandO != operandT);
      OP_BLT:  w_taken = ($signed(operandO) <  $signed(operandT));
      OP_BGE:  w_taken = ($signed(operandO) >= $signed(operandT));
      OP_BLTU: w_taken = (operandO <  operandT);
      OP_BGEU: w_taken = (operandO >= operandT);
      OP_JAL: begin
        w_taken   = 1'b1;
        w_is_link = 1'b1;
      end
      OP_JALR: begin
        w_taken   = 1'b1;
        w_is_link = 1'b1;
        w_is_jalr = 1'b1;
      end
      default: ;
    endcase
  end

  // All target adds wrap silently at the address width.
  assign w_pc_plus4 = PC + ADDR_W'(4);
  assign w_pc_imm   = PC + ADDR_W'(imm);
  assign w_rs_sum   = operandO + imm;
  assign w_rs_sum_a = ADDR_W'(w_rs_sum);
  assign w_jalr_tgt = {w_rs_sum_a[ADDR_W-1:1], 1'b0};

  always_comb begin
    w_target = w_pc_plus4;
    if (w_taken) begin
      w_target = w_is_jalr ? w_jalr_tgt : w_pc_imm;
    end
  end

  // Every accepted branch is queued, taken or not, so fetch always
  // receives a resolution.
  redirect_fifo #(
    .W     (ADDR_W + 1),
    .DEPTH (DEPTH)
  ) u_redirect_fifo (
    .clk          (clk),
    .rst          (rst),
    .i_rdy        (rdy),
    .i_push       (w_accept),
    .i_din        ({w_target, w_taken}),
    .i_pop_ready  (jumpReady),
    .o_head_valid (jumpValid),
    .o_head_data  (w_head),
    .o_full       (branchFull),
    .o_drop       (w_drop)
  );

  assign jumpAddr  = w_head[ADDR_W:1];
  assign jumpTaken = w_head[0];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stat_resolved <= '0;
      r_stat_taken    <= '0;
      r_overflow      <= 1'b0;
    end else begin
      if (w_accept) begin
        r_stat_resolved <= r_stat_resolved + 32'd1;
        if (w_taken) begin
          r_stat_taken <= r_stat_taken + 32'd1;
        end
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // linkEn is a single-cycle pulse: it clears in any cycle without a
  // JAL/JALR accept, including cycles where rdy is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_link_en   <= 1'b0;
      r_link_data <= '0;
    end else begin
      r_link_en <= w_accept & w_is_link;
      if (w_accept && w_is_link) begin
        r_link_data <= DATA_W'(w_pc_plus4);
      end
    end
  end

  assign linkEn       = r_link_en;
  assign linkData     = r_link_data;
  assign overflow     = r_overflow;
  assign statResolved = r_stat_resolved;
  assign statTaken    = r_stat_taken;

endmodule

// File: doc/branch_resolve_unit.md
# branch_resolve_unit

Execution-side consumer of the branch reservation station's issue port. Each cycle it accepts at most one issued branch/jump (`BranchWorkEn` plus operands, immediate, opcode and PC), evaluates the condition, computes the next PC and link value, and queues the resolution into a small redirect FIFO. Fetch drains that FIFO with a valid/ready handshake. The block also keeps resolved/taken statistics counters and raises a full flag so the dispatcher can hold further branch allocation.

## Interface
- `ADDR_W`, 32, instruction address width
- `DATA_W`, 32, operand/data width
- `OP_W`, 6, opcode width (matches `OpBus`)
- `DEPTH`, 2, redirect FIFO entries (power of two, ≥2)

- `clk` in 1: single clock.
- `rst` in 1: reset, synchronous and active-high.
- `rdy` in 1: global enable. When low, all state holds and inputs are ignored.
- `BranchWorkEn` in 1: an issued branch is present this cycle.
- `operandO` in DATA_W: rs1 value.
- `operandT` in DATA_W: rs2 value.
- `imm` in DATA_W: sign-extended offset.
- `opCode` in OP_W: branch/jump opcode.
- `PC` in ADDR_W: address of the branch.
- `jumpValid` out 1: FIFO head is valid.
- `jumpAddr` out ADDR_W: resolved next PC at the FIFO head.
- `jumpTaken` out 1: head was taken (PC ≠ PC+4 path).
- `jumpReady` in 1: fetch accepts the head this cycle.
- `linkEn` out 1: registered pulse for JAL/JALR.
- `linkData` out DATA_W: PC+4 of that jump.
- `branchFull` out 1: FIFO occupancy == DEPTH.
- `overflow` out 1: sticky flag; a push was dropped.
- `statResolved` out 32: count of accepted branches.
- `statTaken` out 32: count of taken branches.

## Operation
- Accept condition: `rdy & BranchWorkEn`. When `rdy` is low, `BranchWorkEn` may stay high because the station holds its output; it is not re-counted.
- Condition evaluation (opcodes from shared defines):
  - BEQ: `O==T`; BNE: `O!=T`.
  - BLT/BGE: signed compare.
  - BLTU/BGEU: unsigned compare.
  - JAL and JALR: always taken.
  - Any other opcode: not-taken, no link.
- Targets; all adds are modulo 2^ADDR_W, so wrap-around is silent:
  - JALR: `(operandO + imm) & ~1`.
  - Branches and JAL: `PC + imm`.
  - Not-taken: `PC + 4`.
- Every accepted branch pushes `{addr, taken}`, whether or not it is taken, so fetch always receives a resolution.
- Pop condition: `jumpValid & jumpReady & rdy`.
- Simultaneous push and pop:
  - Both happen, including when the FIFO is full; occupancy is unchanged.
  - When the FIFO is empty, the pushed entry appears next cycle. There is no bypass.
- Push while full with no pop:
  - The entry is dropped and `overflow` sets (cleared only by `rst`).
  - `statResolved` still increments.
- `linkEn`/`linkData` are registered from JAL/JALR accepts. `linkEn` is low in every other cycle.
- Counters increment on accept (`statTaken` only when taken) and wrap at 2^32.
- Reset values:
  - `jumpValid` 0, `jumpAddr` 0, `jumpTaken` 0.
  - `linkEn` 0, `linkData` 0.
  - `branchFull` 0, `overflow` 0.
  - Both counters 0; FIFO pointers/count 0.
- `rst` mid-operation discards all queued entries on that edge.

## Timing
- Accept in cycle t: the entry is written at the t→t+1 edge.
  - `jumpValid`/`jumpAddr` are visible in t+1 (FIFO was empty) or once earlier entries drain.
  - `linkEn` is high in t+1 only.
- `jumpValid`, `jumpAddr` and `jumpTaken` are registered FIFO-head outputs. They are stable while `jumpReady` is low.
- `branchFull` is combinational from occupancy. The dispatcher must stop allocating branches while it is high; the station adds 1 cycle of issue latency, which DEPTH ≥2 absorbs.
- Throughput: one accept and one pop per cycle.

## Structure
- Shared defines (`defines.v`) hold:
  - the branch opcode constants (BEQ…JALR, NOP);
  - `DataBus`/`InstAddrBus`/`OpBus` widths;
  - `addrFree`/`dataFree`.
- Sub-module `redirect_fifo`: parameterised synchronous FIFO of width ADDR_W+1 and depth DEPTH.
  - Holds the read/write pointers and count.
  - Provides full/empty and registered head outputs.
  - Same `clk`/`rst`/`rdy` semantics.
- Condition/target logic and counters live in the top module.

## Test plan
- BEQ, O=5, T=5, PC=0x100, imm=0x20, `jumpReady`=1 → next cycle `jumpValid`=1, `jumpAddr`=0x120, `jumpTaken`=1. `statTaken`=1.
- BLT O=0xFFFFFFFF, T=1 → taken. BLTU with the same operands → not taken, `jumpAddr`=PC+4.
- JALR O=0x1003, imm=4, PC=0x200 → `jumpAddr`=0x1006, `linkEn` pulse with `linkData`=0x204. BNE with O=T, PC=0xFFFFFFFC → `jumpAddr`=0x0 (wrap).
- `jumpReady`=0, three consecutive accepts → `branchFull` after 2, third dropped, `overflow`=1, `statResolved`=3. Then `jumpReady`=1 → exactly 2 entries drain in order.
- FIFO full with push and pop in the same cycle → no drop, occupancy stays 2, order preserved. `rdy`=0 for 3 cycles with `BranchWorkEn` held → counters unchanged, no push.
- `rst` asserted with 2 queued entries → next cycle `jumpValid`=0, counters 0, `overflow`=0.
